// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: bring-up self-test for the two-input gate library.
// Walks {a,b} through 00..11, lets each vector settle for SETTLE cycles,
// then compares all seven gate outputs against the truth table and reports
// pass, a saturating mismatch count, the first failing vector and a sticky
// mask of failing gates.
// Optional feature: define GATE_SWEEP_CONTINUOUS_EN to let a start held
// during DONE chain straight into the next sweep.

// One gate lane: expected value for gate OP and its mismatch flag.
// OP index matches fail_mask bit order: and, or, not, nand, nor, xor, xnor.
module gate_sweep_lane #(
  parameter int OP = 0
) (
  input  logic a,
  input  logic b,
  input  logic y,
  output logic mis
);
  logic exp_y;

  // Truth table for this lane's gate; `not` only looks at a.
  always_comb begin
    exp_y = 1'b0;
    case (OP)
      0:       exp_y = a & b;
      1:       exp_y = a | b;
      2:       exp_y = ~a;
      3:       exp_y = ~(a & b);
      4:       exp_y = ~(a | b);
      5:       exp_y = a ^ b;
      6:       exp_y = ~(a ^ b);
      default: exp_y = 1'b0;
    endcase
  end

  assign mis = (y != exp_y);
endmodule

module gate_sweep_checker #(
  parameter int SETTLE = 2,
  parameter int ERRW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            a,
  output logic            b,
  input  logic            y_and,
  input  logic            y_or,
  input  logic            y_not,
  input  logic            y_nand,
  input  logic            y_nor,
  input  logic            y_xor,
  input  logic            y_xnor,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_cnt,
  output logic [1:0]      fail_vec,
  output logic [6:0]      fail_mask
);
  localparam int NUM_GATES = 7;
  localparam int CW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SW        = ERRW + 3;   // room for err_cnt + up to 7 per vector
  localparam logic [ERRW-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t                 state, state_n;
  logic [1:0]             vec, vec_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [ERRW-1:0]        err_n;
  logic [1:0]             fvec_n;
  logic [6:0]             mask_n;
  logic                   pass_n;
  logic [NUM_GATES-1:0]   y_vec, m;
  logic [2:0]             pop;
  logic [SW-1:0]          err_sum;
  logic [ERRW-1:0]        err_sat;
  logic                   go;

  assign y_vec = {y_xnor, y_xor, y_nor, y_nand, y_not, y_or, y_and};

  // Per-gate mismatch lanes, all fed from the registered vector.
  for (genvar i = 0; i < NUM_GATES; i++) begin : g_lane
    gate_sweep_lane #(.OP(i)) u_lane (
      .a   (vec[1]),
      .b   (vec[0]),
      .y   (y_vec[i]),
      .mis (m[i])
    );
  end

  // Mismatch popcount folded into the running count, clamped at all-ones.
  always_comb begin
    pop = 3'd0;
    for (int i = 0; i < NUM_GATES; i++) pop = pop + 3'(m[i]);
    err_sum = {3'b000, err_cnt} + SW'(pop);
    err_sat = (err_sum > {3'b000, ERR_MAX}) ? ERR_MAX : err_sum[ERRW-1:0];
  end

  // Sweep FSM: next state, vector/counter and result updates.
  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    err_n   = err_cnt;
    fvec_n  = fail_vec;
    mask_n  = fail_mask;
    pass_n  = pass;
    go      = 1'b0;
    case (state)
      S_IDLE:  go = start;
      S_WAIT: begin
        if (cnt == CW'(SETTLE - 1)) state_n = S_CHECK;
        else                        cnt_n   = cnt + 1'b1;
      end
      S_CHECK: begin
        mask_n = fail_mask | m;
        err_n  = err_sat;
        // fail_mask still zero means no earlier vector of this sweep failed.
        if ((m != '0) && (fail_mask == '0)) fvec_n = vec;
        if (vec == 2'b11) begin
          state_n = S_DONE;
          pass_n  = (err_sat == '0);
        end else begin
          state_n = S_WAIT;
          vec_n   = vec + 2'b01;
          cnt_n   = '0;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
`ifdef GATE_SWEEP_CONTINUOUS_EN
        go = start;
`endif
      end
      default: state_n = S_IDLE;
    endcase
    // Accepted start: fresh sweep from vector 00 with cleared results.
    if (go) begin
      state_n = S_WAIT;
      vec_n   = 2'b00;
      cnt_n   = '0;
      err_n   = '0;
      fvec_n  = 2'b00;
      mask_n  = '0;
      pass_n  = 1'b0;
    end
  end

  // State and result registers; reset abandons any sweep in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      vec       <= 2'b00;
      cnt       <= '0;
      err_cnt   <= '0;
      fail_vec  <= 2'b00;
      fail_mask <= '0;
      pass      <= 1'b0;
    end else begin
      state     <= state_n;
      vec       <= vec_n;
      cnt       <= cnt_n;
      err_cnt   <= err_n;
      fail_vec  <= fvec_n;
      fail_mask <= mask_n;
      pass      <= pass_n;
    end
  end

  // Outputs decode registered state only; y_* never reach them directly.
  assign a    = vec[1];
  assign b    = vec[0];
  assign busy = (state == S_WAIT) || (state == S_CHECK);
  assign done = (state == S_DONE);
endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker (SETTLE=2, ERRW=4) with a
// behavioural gate model that can be faulted per test.
module tb_gate_sweep_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       a, b;
  logic       y_and, y_or, y_not, y_nand, y_nor, y_xor, y_xnor;
  logic       busy, done, pass;
  logic [3:0] err_cnt;
  logic [1:0] fail_vec;
  logic [6:0] fail_mask;
  int         mode = 0;   // 0 good, 1 xor stuck-0, 2 all outputs inverted
  int         n_chk = 0;
  int         n_pass = 0;

  typedef struct {
    int         mode;
    logic       pass;
    logic [3:0] err;
    logic [1:0] fvec;
    logic [6:0] mask;
  } vec_t;

  vec_t tbl[3];

  gate_sweep_checker #(.SETTLE(2), .ERRW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .y_and(y_and), .y_or(y_or), .y_not(y_not), .y_nand(y_nand),
    .y_nor(y_nor), .y_xor(y_xor), .y_xnor(y_xnor),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_vec(fail_vec), .fail_mask(fail_mask)
  );

  always #5 clk = ~clk;

  // Gate library model with injectable faults.
  always_comb begin
    y_and  = a & b;
    y_or   = a | b;
    y_not  = ~a;
    y_nand = ~(a & b);
    y_nor  = ~(a | b);
    y_xor  = a ^ b;
    y_xnor = ~(a ^ b);
    if (mode == 1) y_xor = 1'b0;
    if (mode == 2) begin
      y_and  = ~(a & b);
      y_or   = ~(a | b);
      y_not  = a;
      y_nand = a & b;
      y_nor  = a | b;
      y_xor  = ~(a ^ b);
      y_xnor = a ^ b;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One pulsed-start sweep; c counts edges after the accepting edge k.
  task automatic run_sweep(input vec_t v, input bit repulse);
    int ndone;
    ndone = 0;
    mode  = v.mode;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c <= 25; c++) begin
      if (c % 3 == 0 && c <= 9) begin
        chk("vector", {30'd0, a, b}, 32'(c / 3));
        chk("busy_sweep", busy, 1);
      end
      if (c == 0) begin
        chk("clr_err", err_cnt, 0);
        chk("clr_pass", pass, 0);
        chk("clr_mask", fail_mask, 0);
      end
      if (v.mode == 2 && c == 9) chk("err_sat_mid", err_cnt, 15);
      if (c == 12) begin
        chk("done_at_12", done, 1);
        chk("busy_done", busy, 0);
        chk("pass", pass, v.pass);
        chk("err_cnt", err_cnt, v.err);
        chk("fail_vec", fail_vec, v.fvec);
        chk("fail_mask", fail_mask, v.mask);
      end
      if (c == 13) begin
        chk("hold_err", err_cnt, v.err);
        chk("hold_mask", fail_mask, v.mask);
        chk("idle_busy", busy, 0);
      end
      if (repulse && c == 5) start = 1'b1;
      if (repulse && c == 6) start = 1'b0;
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("done_once", ndone, 1);
  endtask

  initial begin
    int ndone;
    bit ok;
    tbl[0] = '{mode: 0, pass: 1'b1, err: 4'd0,  fvec: 2'b00, mask: 7'b0000000};
    tbl[1] = '{mode: 1, pass: 1'b0, err: 4'd2,  fvec: 2'b01, mask: 7'b0100000};
    tbl[2] = '{mode: 2, pass: 1'b0, err: 4'd15, fvec: 2'b00, mask: 7'b1111111};

    // Reset values.
    #12;
    chk("rst_ab", {a, b}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_fvec", fail_vec, 0);
    chk("rst_mask", fail_mask, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    // Table-driven sweeps.
    for (int i = 0; i < 3; i++) run_sweep(tbl[i], 1'b0);

    // start re-pulsed during CHECK of vector 01 is ignored.
    run_sweep(tbl[0], 1'b1);

    // Async reset during WAIT of vector 10 (faulty gates so results are nonzero).
    mode = 2;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_err", err_cnt, 14);
    #2 rst = 1'b1;
    #1;
    chk("arst_ab", {a, b}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_mask", fail_mask, 0);
    chk("arst_fvec", fail_vec, 0);
    chk("arst_pass", pass, 0);
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("arst_no_done", ndone, 0);
    run_sweep(tbl[0], 1'b0);

    // start held high through edge 13 (sampled in DONE).
    mode = 0;
    ndone = 0;
    ok = 1'b1;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c <= 27; c++) begin
      if (done) ndone++;
      if (c == 12) chk("hold_done_12", done, 1);
`ifdef GATE_SWEEP_CONTINUOUS_EN
      if (c == 13) begin
        chk("cont_busy_13", busy, 1);
        chk("cont_vec_13", {a, b}, 0);
      end
      if (c == 25) begin
        chk("cont_done_25", done, 1);
        chk("cont_pass", pass, 1);
      end
`else
      if (c >= 13 && busy) ok = 1'b0;
`endif
      if (c == 13) start = 1'b0;
      @(posedge clk); #1;
    end
`ifdef GATE_SWEEP_CONTINUOUS_EN
    chk("cont_done_count", ndone, 2);
`else
    chk("single_done_count", ndone, 1);
    chk("stays_idle", ok, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
